// File: rtl/servo_pkg.sv
// Shared definitions for the servo chain: FSM states, position codes and default dwell.
package servo_pkg;

  typedef enum logic [1:0] {
    DESLIGADO = 2'b00,
    SUBINDO   = 2'b01,
    DESCENDO  = 2'b10
  } estado_t;

  // Position codes, also decoded by controle_servo into pulse widths.
  localparam logic [1:0] POS_OFF   = 2'b00;
  localparam logic [1:0] POS_1MS   = 2'b01;
  localparam logic [1:0] POS_1_5MS = 2'b10;
  localparam logic [1:0] POS_2MS   = 2'b11;

  // 500 ms at a 50 MHz clock.
  localparam int T_PASSO_500MS = 25_000_000;

endpackage

// File: rtl/contador_passo.sv
// Modulo-T_PASSO dwell counter; fim flags the last cycle of each dwell period.
module contador_passo #(
  parameter int T_PASSO = servo_pkg::T_PASSO_500MS
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = $clog2(T_PASSO);
  localparam logic [W-1:0] ULTIMO = W'(T_PASSO - 1);

  logic [W-1:0] contagem;

  // Wraps to zero at ULTIMO, so the count never leaves 0..T_PASSO-1.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      contagem <= '0;
    end else if (conta) begin
      if (contagem == ULTIMO) begin
        contagem <= '0;
      end else begin
        contagem <= contagem + 1'b1;
      end
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/varredura_servo.sv
// Sweep sequencer: steps posicao 01->10->11->10->01... every T_PASSO cycles while ligar is high.
module varredura_servo
  import servo_pkg::*;
#(
  parameter int T_PASSO = T_PASSO_500MS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  output logic [1:0] posicao,
  output logic       passo,
  output logic       sentido,
  output logic [1:0] db_estado
);

  estado_t    estado, estado_n;
  logic [1:0] posicao_n;
  logic       passo_n;
  logic       sentido_n;
  logic       zera;
  logic       fim;

  // The timer only runs in a sweep state with ligar still high, so every
  // (re)entry starts a full dwell from zero.
  assign zera = (estado == DESLIGADO) || !ligar;

  contador_passo #(
    .T_PASSO(T_PASSO)
  ) u_contador (
    .clock(clock),
    .reset(reset),
    .zera (zera),
    .conta(1'b1),
    .fim  (fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= DESLIGADO;
      posicao <= POS_OFF;
      passo   <= 1'b0;
      sentido <= 1'b0;
    end else begin
      estado  <= estado_n;
      posicao <= posicao_n;
      passo   <= passo_n;
      sentido <= sentido_n;
    end
  end

  // Disable is checked before expiry so a falling ligar suppresses the step.
  always_comb begin
    estado_n  = estado;
    posicao_n = posicao;
    passo_n   = 1'b0;
    case (estado)
      DESLIGADO: begin
        posicao_n = POS_OFF;
        if (ligar) begin
          estado_n  = SUBINDO;
          posicao_n = POS_1MS;
        end
      end
      SUBINDO: begin
        if (!ligar) begin
          estado_n  = DESLIGADO;
          posicao_n = POS_OFF;
        end else if (fim) begin
          passo_n = 1'b1;
          if (posicao == POS_2MS) begin
            estado_n  = DESCENDO;
            posicao_n = POS_1_5MS;
          end else begin
            posicao_n = posicao + 2'd1;
          end
        end
      end
      DESCENDO: begin
        if (!ligar) begin
          estado_n  = DESLIGADO;
          posicao_n = POS_OFF;
        end else if (fim) begin
          passo_n = 1'b1;
          if (posicao == POS_1MS) begin
            estado_n  = SUBINDO;
            posicao_n = POS_1_5MS;
          end else begin
            posicao_n = posicao - 2'd1;
          end
        end
      end
      default: begin
        estado_n  = DESLIGADO;
        posicao_n = POS_OFF;
      end
    endcase
    sentido_n = (estado_n == SUBINDO);
  end

  assign db_estado = estado;

endmodule
